// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer (IDLE/RUN/HALT) driving the instruction ROM address.
// Define FETCH_INST_COUNT_EN to build the saturating executed-instruction counter.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             Ack,
    input  logic             FlagWrEn,
    input  logic             ZeroIn,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state, next_state;
    logic [PC_W-1:0] pc, next_pc;
    logic            eq_flag, next_eq_flag;
    logic            running, done;
    logic            start_ok;

    // Start is only honoured outside RUN.
    assign start_ok = Start && (state != RUN);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            pc      <= '0;
            eq_flag <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            pc      <= next_pc;
            eq_flag <= next_eq_flag;
            running <= (next_state == RUN);
            done    <= (next_state == HALT);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, HALT: if (Start) next_state = RUN;
            RUN:        if (Ack)   next_state = HALT;
            default:    next_state = IDLE;
        endcase
    end

    // Branches resolve against the registered flag, not the value being written this cycle.
    always_comb begin
        next_pc      = pc;
        next_eq_flag = eq_flag;
        if (start_ok) begin
            next_pc      = StartAddr;
            next_eq_flag = 1'b0;
        end else if (state == RUN) begin
            if (FlagWrEn) next_eq_flag = ZeroIn;
            if (Ack)
                next_pc = pc;
            else if (JumpEqual)
                next_pc = eq_flag ? Target : pc + 1'b1;
            else if (JumpNotEqual && !eq_flag)
                next_pc = Target;
            else
                next_pc = pc + 1'b1;
        end
    end

`ifdef FETCH_INST_COUNT_EN
    logic [CNT_W-1:0] inst_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            inst_count <= '0;
        else if (start_ok)
            inst_count <= '0;
        else if (state == RUN && inst_count != '1)
            inst_count <= inst_count + 1'b1;
    end

    assign InstCount = inst_count;
`else
    assign InstCount = '0;
`endif

    assign ProgCtr = pc;
    assign Running = running;
    assign Done    = done;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; counter checks follow FETCH_INST_COUNT_EN.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start, JumpEqual, JumpNotEqual, Ack, FlagWrEn, ZeroIn;
    logic [9:0]  StartAddr, Target;
    logic [9:0]  ProgCtr;
    logic        Running, Done;
    logic [15:0] InstCount;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .Ack(Ack),
        .FlagWrEn(FlagWrEn), .ZeroIn(ZeroIn), .Target(Target),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .InstCount(InstCount)
    );

`ifdef FETCH_INST_COUNT_EN
    logic [9:0] pc4;
    logic       run4, done4;
    logic [3:0] cnt4;

    fetch_unit #(.PC_W(10), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .JumpEqual(JumpEqual), .JumpNotEqual(JumpNotEqual), .Ack(Ack),
        .FlagWrEn(FlagWrEn), .ZeroIn(ZeroIn), .Target(Target),
        .ProgCtr(pc4), .Running(run4), .Done(done4), .InstCount(cnt4)
    );
`endif

    always #5 Clk = ~Clk;

    always @(posedge Clk)
        if (Running)
            assert (!(JumpEqual && JumpNotEqual)) else $error("je and jne both high");

    typedef struct {
        logic       st;
        logic [9:0] sa;
        logic       je, jne, ack, fwe, zin;
        logic [9:0] tgt;
        logic [9:0] pc;
        logic       run, done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic st, logic [9:0] sa, logic je, logic jne, logic ack,
                                logic fwe, logic zin, logic [9:0] tgt, logic [9:0] pc,
                                logic run, logic done, logic [15:0] cnt);
        vec_t v;
        v.st = st; v.sa = sa; v.je = je; v.jne = jne; v.ack = ack;
        v.fwe = fwe; v.zin = zin; v.tgt = tgt; v.pc = pc;
        v.run = run; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [15:0] exp_cnt(logic [15:0] c);
`ifdef FETCH_INST_COUNT_EN
        return c;
`else
        return 16'd0;
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, clock once, sample at the next falling edge.
    task automatic step(logic st, logic [9:0] sa, logic je, logic jne, logic ack,
                        logic fwe, logic zin, logic [9:0] tgt);
        Start = st; StartAddr = sa; JumpEqual = je; JumpNotEqual = jne;
        Ack = ack; FlagWrEn = fwe; ZeroIn = zin; Target = tgt;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_all(string tag, logic [9:0] pc, logic run, logic done, logic [15:0] cnt);
        check({tag, " pc"},   {22'd0, ProgCtr},   {22'd0, pc});
        check({tag, " run"},  {31'd0, Running},   {31'd0, run});
        check({tag, " done"}, {31'd0, Done},      {31'd0, done});
        check({tag, " cnt"},  {16'd0, InstCount}, {16'd0, exp_cnt(cnt)});
    endtask

    initial begin
        //            st  sa     je jne ack fwe zin tgt     pc     run done cnt
        vecs[0]  = mk(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0); // idle
        vecs[1]  = mk(1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 10'h010, 1, 0, 0); // start
        vecs[2]  = mk(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h011, 1, 0, 1);
        vecs[3]  = mk(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h012, 1, 0, 2);
        vecs[4]  = mk(1, 10'h200, 0, 0, 0, 0, 0, 10'h000, 10'h013, 1, 0, 3); // start ignored in RUN
        vecs[5]  = mk(0, 10'h000, 0, 0, 1, 0, 0, 10'h000, 10'h013, 0, 1, 4); // ack
        vecs[6]  = mk(0, 10'h000, 0, 0, 0, 1, 1, 10'h000, 10'h013, 0, 1, 4); // fwe ignored in HALT
        vecs[7]  = mk(1, 10'h020, 0, 0, 0, 0, 0, 10'h000, 10'h020, 1, 0, 0); // restart
        vecs[8]  = mk(0, 10'h000, 1, 0, 0, 1, 1, 10'h300, 10'h021, 1, 0, 1); // je old flag 0
        vecs[9]  = mk(0, 10'h000, 1, 0, 0, 0, 0, 10'h100, 10'h100, 1, 0, 2); // je taken
        vecs[10] = mk(0, 10'h000, 0, 0, 0, 1, 0, 10'h000, 10'h101, 1, 0, 3); // flag <= 0
        vecs[11] = mk(0, 10'h000, 1, 0, 0, 0, 0, 10'h200, 10'h102, 1, 0, 4); // je not taken
        vecs[12] = mk(0, 10'h000, 0, 1, 0, 1, 1, 10'h050, 10'h050, 1, 0, 5); // hazard: jne on old flag
        vecs[13] = mk(0, 10'h000, 0, 1, 0, 0, 0, 10'h150, 10'h051, 1, 0, 6); // flag now 1
        vecs[14] = mk(0, 10'h000, 1, 0, 0, 0, 0, 10'h3FF, 10'h3FF, 1, 0, 7);
        vecs[15] = mk(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 8); // wrap
        vecs[16] = mk(0, 10'h000, 1, 0, 1, 0, 0, 10'h123, 10'h000, 0, 1, 9); // ack beats je
        vecs[17] = mk(1, 10'h3FF, 0, 0, 0, 0, 0, 10'h000, 10'h3FF, 1, 0, 0); // flag cleared
        vecs[18] = mk(0, 10'h000, 0, 1, 0, 0, 0, 10'h033, 10'h033, 1, 0, 1);
        vecs[19] = mk(0, 10'h000, 0, 0, 1, 0, 0, 10'h000, 10'h033, 0, 1, 2);
        vecs[20] = mk(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h033, 0, 1, 2);
        vecs[21] = mk(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);

        Reset_n = 1'b0;
        Start = 0; StartAddr = '0; JumpEqual = 0; JumpNotEqual = 0;
        Ack = 0; FlagWrEn = 0; ZeroIn = 0; Target = '0;
        repeat (2) @(negedge Clk);
        check_all("reset", 10'h000, 0, 0, 0);
        Reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].st, vecs[i].sa, vecs[i].je, vecs[i].jne, vecs[i].ack,
                 vecs[i].fwe, vecs[i].zin, vecs[i].tgt);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].cnt);
        end

        // Async reset mid-RUN with a branch pending on the inputs.
        repeat (3) step(0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
        check_all("prerst", 10'h003, 1, 0, 3);
        JumpNotEqual = 1; Target = 10'h2AA;
        #2 Reset_n = 1'b0;
        #1 check_all("midrst", 10'h000, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step(0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
        check_all("postrst", 10'h000, 0, 0, 0);

        // Five sequential instructions then Ack: six RUN cycles counted.
        step(1, 10'h040, 0, 0, 0, 0, 0, 10'h000);
        repeat (5) step(0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
        check_all("seq5", 10'h045, 1, 0, 5);
        step(0, 10'h000, 0, 0, 1, 0, 0, 10'h000);
        check_all("ack6", 10'h045, 0, 1, 6);
        step(0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
        check_all("hold6", 10'h045, 0, 1, 6);

        // Twenty-cycle run crossing the PC wrap; narrow counter saturates.
        step(1, 10'h3F0, 0, 0, 0, 0, 0, 10'h000);
        repeat (20) step(0, 10'h000, 0, 0, 0, 0, 0, 10'h000);
        check_all("run20", 10'h004, 1, 0, 20);
`ifdef FETCH_INST_COUNT_EN
        check("cnt4 sat", {28'd0, cnt4}, 32'd15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
